// File: rtl/otter_io_pkg.sv
// Shared definitions for OTTER IOBUS peripherals: timer register offsets,
// CTRL field layout and CTRL pack/unpack helpers.
package otter_io_pkg;

    localparam int unsigned BUS_W = 32;
    localparam int unsigned PRE_W = 8;

    // Register select values taken from IOBUS_ADDR[3:2]
    localparam logic [1:0] TMR_CTRL  = 2'd0;
    localparam logic [1:0] TMR_COUNT = 2'd1;
    localparam logic [1:0] TMR_CMP   = 2'd2;
    localparam logic [1:0] TMR_STAT  = 2'd3;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_AUTO_BIT   = 1;
    localparam int unsigned CTRL_IRQEN_BIT  = 2;
    localparam int unsigned CTRL_PRE_LSB    = 8;
    localparam int unsigned CTRL_PRE_MSB    = 15;
    localparam int unsigned STAT_PEND_BIT   = 0;

    typedef struct packed {
        logic [PRE_W-1:0] prescale;
        logic             irq_en;
        logic             auto_reload;
        logic             en;
    } tmr_ctrl_t;

    function automatic tmr_ctrl_t word_to_ctrl(input logic [BUS_W-1:0] w);
        tmr_ctrl_t c;
        c.prescale    = w[CTRL_PRE_MSB:CTRL_PRE_LSB];
        c.irq_en      = w[CTRL_IRQEN_BIT];
        c.auto_reload = w[CTRL_AUTO_BIT];
        c.en          = w[CTRL_EN_BIT];
        return c;
    endfunction

    // Unused CTRL bits read back as 0
    function automatic logic [BUS_W-1:0] ctrl_to_word(input tmr_ctrl_t c);
        logic [BUS_W-1:0] w;
        w = '0;
        w[CTRL_PRE_MSB:CTRL_PRE_LSB] = c.prescale;
        w[CTRL_IRQEN_BIT]            = c.irq_en;
        w[CTRL_AUTO_BIT]             = c.auto_reload;
        w[CTRL_EN_BIT]               = c.en;
        return w;
    endfunction

endpackage

// File: rtl/otter_io_timer_if.sv
// OTTER IOBUS connection between the CPU (master) and an IO peripheral (slave).
interface otter_io_timer_if;
    import otter_io_pkg::*;

    logic [BUS_W-1:0] IOBUS_ADDR;
    logic [BUS_W-1:0] IOBUS_OUT;
    logic             IOBUS_WR;
    logic [BUS_W-1:0] IOBUS_IN;

    modport master (
        output IOBUS_ADDR,
        output IOBUS_OUT,
        output IOBUS_WR,
        input  IOBUS_IN
    );

    modport slave (
        input  IOBUS_ADDR,
        input  IOBUS_OUT,
        input  IOBUS_WR,
        output IOBUS_IN
    );

endinterface

// File: rtl/otter_io_prescaler.sv
// Free-running prescaler: counts 0..limit while enabled and flags a tick on
// the cycle it sits at limit; held at 0 when disabled, cleared, or in reset.
module otter_io_prescaler
    import otter_io_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] limit,
    output logic             tick
);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             at_lim;

    assign at_lim = (pre_q == limit);
    // Tick is suppressed during reset so no counter update leaks through
    assign tick   = en & ~RESET & at_lim;

    always_comb begin
        pre_d = pre_q;
        if (clr || !en || at_lim) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/otter_io_timer.sv
// Memory-mapped interval timer on the OTTER IOBUS: CTRL/COUNT/COMPARE/STATUS
// registers, prescaled counting, compare-match level interrupt.
module otter_io_timer
    import otter_io_pkg::*;
#(
    parameter logic [BUS_W-1:0] BASE_ADDR = 32'h1100_0100,
    parameter int unsigned      CNT_W     = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    otter_io_timer_if.slave   bus,
    output logic              INTR
);

    tmr_ctrl_t        ctrl_q,  ctrl_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] cmp_q,   cmp_d;
    logic             pend_q,  pend_d;

    logic             hit;
    logic [1:0]       sel;
    logic             wr_hit;
    logic             wr_ctrl;
    logic             wr_count;
    logic             wr_cmp;
    logic             wr_stat;
    logic             tick;
    logic             match;
    logic [CNT_W-1:0] wdata;
    logic [BUS_W-1:0] rdata;
    logic             unused_addr_lsbs;

    // Address decode; byte-lane bits are ignored, all accesses are full-word
    assign hit      = (bus.IOBUS_ADDR[BUS_W-1:4] == BASE_ADDR[BUS_W-1:4]);
    assign sel      = bus.IOBUS_ADDR[3:2];
    assign wr_hit   = bus.IOBUS_WR & hit;
    assign wr_ctrl  = wr_hit & (sel == TMR_CTRL);
    assign wr_count = wr_hit & (sel == TMR_COUNT);
    assign wr_cmp   = wr_hit & (sel == TMR_CMP);
    assign wr_stat  = wr_hit & (sel == TMR_STAT);
    assign wdata    = bus.IOBUS_OUT[CNT_W-1:0];
    assign match    = (count_q == cmp_q);

    assign unused_addr_lsbs = ^bus.IOBUS_ADDR[1:0];

    otter_io_prescaler u_prescaler (
        .CLK   (CLK),
        .RESET (RESET),
        .en    (ctrl_q.en),
        .clr   (wr_ctrl),
        .limit (ctrl_q.prescale),
        .tick  (tick)
    );

    // Next state; statement order encodes priority (later assignment wins)
    always_comb begin
        ctrl_d  = ctrl_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        pend_d  = pend_q;

        if (wr_stat && bus.IOBUS_OUT[STAT_PEND_BIT]) begin
            pend_d = 1'b0;
        end

        if (tick && !wr_count) begin
            if (match) begin
                pend_d = 1'b1;
                if (ctrl_q.auto_reload) begin
                    count_d = '0;
                end else begin
                    ctrl_d.en = 1'b0;
                end
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end

        if (wr_count) begin
            count_d = wdata;
        end
        if (wr_cmp) begin
            cmp_d = wdata;
        end
        if (wr_ctrl) begin
            ctrl_d = word_to_ctrl(bus.IOBUS_OUT);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_q  <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            pend_q  <= pend_d;
        end
    end

    // Zero-latency read mux; the CPU memory stage samples in the same cycle
    always_comb begin
        rdata = '0;
        if (hit) begin
            case (sel)
                TMR_CTRL:  rdata = ctrl_to_word(ctrl_q);
                TMR_COUNT: rdata = BUS_W'(count_q);
                TMR_CMP:   rdata = BUS_W'(cmp_q);
                TMR_STAT:  rdata = BUS_W'(pend_q);
                default:   rdata = '0;
            endcase
        end
    end

    assign bus.IOBUS_IN = rdata;
    assign INTR         = pend_q & ctrl_q.irq_en;

endmodule

// File: tb/tb_otter_io_timer.sv
// Directed bench for otter_io_timer: register access, auto-reload, one-shot
// with prescale, same-cycle priorities, wrap, and mid-run reset.
module tb_otter_io_timer;

    localparam logic [31:0] A_CTRL = 32'h1100_0100;
    localparam logic [31:0] A_CNT  = 32'h1100_0104;
    localparam logic [31:0] A_CMP  = 32'h1100_0108;
    localparam logic [31:0] A_STAT = 32'h1100_010C;

    logic CLK;
    logic RESET;
    logic INTR;
    int   npass;
    int   ntot;

    otter_io_timer_if bus ();

    otter_io_timer #(
        .BASE_ADDR (32'h1100_0100),
        .CNT_W     (32)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave),
        .INTR  (INTR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.IOBUS_ADDR = a;
        bus.IOBUS_OUT  = d;
        bus.IOBUS_WR   = 1'b1;
        cyc();
        bus.IOBUS_WR   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.IOBUS_ADDR = a;
        #1;
        check(tag, bus.IOBUS_IN, exp);
    endtask

    task automatic chk_intr(input string tag, input logic exp);
        check(tag, {31'b0, INTR}, {31'b0, exp});
    endtask

    initial begin
        npass = 0;
        ntot  = 0;
        RESET = 1'b1;
        bus.IOBUS_ADDR = '0;
        bus.IOBUS_OUT  = '0;
        bus.IOBUS_WR   = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        // 1. reset values and plain register access
        rd("rst_ctrl", A_CTRL, 32'h0);
        rd("rst_count", A_CNT, 32'h0);
        rd("rst_cmp", A_CMP, 32'h0);
        rd("rst_stat", A_STAT, 32'h0);
        chk_intr("rst_intr", 1'b0);
        wr(A_CMP, 32'hDEAD_BEEF);
        rd("cmp_rb", A_CMP, 32'hDEAD_BEEF);
        rd("miss_rd", 32'h1100_0110, 32'h0);
        wr(32'h1100_0118, 32'h0000_1234);
        rd("miss_wr", A_CMP, 32'hDEAD_BEEF);
        rd("addr_lsb", 32'h1100_010B, 32'hDEAD_BEEF);

        // 2. auto-reload period of 4 ticks
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'h0000_0007);
        rd("ar_c0", A_CNT, 32'd0);
        cyc(); rd("ar_c1", A_CNT, 32'd1);
        cyc(); rd("ar_c2", A_CNT, 32'd2);
        cyc(); rd("ar_c3", A_CNT, 32'd3);
        chk_intr("ar_intr_pre", 1'b0);
        cyc(); rd("ar_reload", A_CNT, 32'd0);
        chk_intr("ar_intr_rise", 1'b1);
        wr(A_STAT, 32'h1);
        chk_intr("ar_w1c", 1'b0);
        rd("ar_c1b", A_CNT, 32'd1);
        cyc(); chk_intr("ar_low2", 1'b0);
        cyc(); chk_intr("ar_low3", 1'b0);
        rd("ar_c3b", A_CNT, 32'd3);
        cyc(); chk_intr("ar_reassert", 1'b1);
        rd("ar_c0b", A_CNT, 32'd0);

        // 3. one-shot with PRESCALE=2
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h1);
        wr(A_CNT, 32'h0);
        wr(A_CMP, 32'd2);
        wr(A_CTRL, 32'h0000_0205);
        rd("os_stat0", A_STAT, 32'h0);
        cyc(); cyc(); rd("os_f2", A_CNT, 32'd0);
        cyc();        rd("os_f3", A_CNT, 32'd1);
        cyc(); cyc(); rd("os_f5", A_CNT, 32'd1);
        cyc();        rd("os_f6", A_CNT, 32'd2);
        cyc(); cyc(); rd("os_f8_stat", A_STAT, 32'h0);
        cyc();
        rd("os_ctrl_stop", A_CTRL, 32'h0000_0204);
        rd("os_hold", A_CNT, 32'd2);
        rd("os_pend", A_STAT, 32'h1);
        chk_intr("os_intr", 1'b1);
        cyc(); rd("os_hold2", A_CNT, 32'd2);

        // 4a. match set beats STATUS clear in the same cycle
        wr(A_STAT, 32'h1);
        rd("col_clr", A_STAT, 32'h0);
        wr(A_CTRL, 32'h0000_0003);
        wr(A_STAT, 32'h1);
        rd("col_pend", A_STAT, 32'h1);
        rd("col_reload", A_CNT, 32'd0);
        chk_intr("col_irq_gate", 1'b0);

        // 4b. COUNT write beats tick increment
        wr(A_CNT, 32'd100);
        rd("col_cnt_wr", A_CNT, 32'd100);
        cyc(); rd("col_cnt_next", A_CNT, 32'd101);

        // 4c. CTRL write beats one-shot EN clear
        wr(A_CTRL, 32'h0);
        wr(A_CNT, 32'd2);
        wr(A_CTRL, 32'h0000_0001);
        wr(A_CTRL, 32'h0000_0001);
        rd("col_ctrl_keep", A_CTRL, 32'h0000_0001);
        rd("col_ctrl_cnt", A_CNT, 32'd2);
        cyc(); rd("col_ctrl_stop", A_CTRL, 32'h0);

        // 5. wrap at all-ones without a flag
        wr(A_STAT, 32'h1);
        wr(A_CNT, 32'hFFFF_FFFF);
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'h0000_0005);
        rd("wr_max", A_CNT, 32'hFFFF_FFFF);
        cyc();
        rd("wr_zero", A_CNT, 32'h0);
        rd("wr_noflag", A_STAT, 32'h0);
        chk_intr("wr_nointr", 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            rd($sformatf("wr_c%0d", i), A_CNT, 32'(i));
        end
        chk_intr("wr_intr_pre", 1'b0);
        cyc();
        chk_intr("wr_intr_fire", 1'b1);
        rd("wr_hold", A_CNT, 32'd5);

        // 6. reset pulse mid-operation
        wr(A_CTRL, 32'h0000_0007);
        chk_intr("mr_intr_on", 1'b1);
        cyc();
        rd("mr_reload", A_CNT, 32'd0);
        cyc();
        rd("mr_count", A_CNT, 32'd1);
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        rd("mr_ctrl", A_CTRL, 32'h0);
        rd("mr_cnt", A_CNT, 32'h0);
        rd("mr_cmp", A_CMP, 32'h0);
        rd("mr_stat", A_STAT, 32'h0);
        chk_intr("mr_intr", 1'b0);
        cyc(); cyc();
        rd("mr_idle", A_CNT, 32'h0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/otter_io_timer.md
Name: otter_io_timer

Overview:
- Memory-mapped interval timer that responds on the OTTER IOBUS; the CPU is the initiator.
- Decodes IOBUS_ADDR/IOBUS_WR, accepts register writes from IOBUS_OUT, and returns read data on IOBUS_IN.
- Raises a level interrupt to the CPU's INTR input on compare match.
- Sits in the top-level wrapper beside OTTER_MCU as an IO peripheral.

Parameters:
- BASE_ADDR, 32'h1100_0100, word-aligned base of the 16-byte register window.
- CNT_W, 32, counter and compare width (legal values 16..32; registers zero-extend to 32 bits on read).

Ports:
- CLK  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- IOBUS_ADDR  input  32  CPU byte address.
- IOBUS_OUT  input  32  CPU write data.
- IOBUS_WR  input  1  one-cycle write strobe, qualified by address hit.
- IOBUS_IN  output  32  read data for the addressed register; 0 when no hit.
- INTR  output  1  level interrupt = irq_pending & CTRL.IRQ_EN.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (CLK, RESET).
- Address hit: IOBUS_ADDR[31:4] == BASE_ADDR[31:4]. Register select is IOBUS_ADDR[3:2]. Bits [1:0] are ignored; all accesses are full-word.
- Register map (byte offsets):
  - 0x0 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [15:8] PRESCALE. Other bits read 0.
  - 0x4 COUNT: read/write.
  - 0x8 COMPARE: read/write.
  - 0xC STATUS: [0] irq_pending, write-1-to-clear; other bits read 0 and ignore writes.
- Reads: combinational from current register state, zero latency. The value is valid in the same cycle the address is presented, because the CPU memory stage samples IO_IN then. No read side effects.
- Writes: take effect at the rising edge where IOBUS_WR=1 and the address hits. Writes with IOBUS_WR=1 but no hit are ignored.
- Prescaler: 8-bit pre_cnt.
  - When EN=1: pre_cnt increments each cycle. When pre_cnt==PRESCALE, tick=1 for that cycle and pre_cnt<=0.
  - PRESCALE=0 gives a tick every cycle.
  - EN=0 holds pre_cnt at 0.
  - Any CTRL write clears pre_cnt.
- Counter, on tick:
  - If COUNT==COMPARE: set irq_pending. If AUTO_RELOAD=1, COUNT<=0. Otherwise COUNT holds and EN<=0 (one-shot stop).
  - Else COUNT<=COUNT+1, wrapping at 2^CNT_W-1 to 0 with no flag.
- Priority, same cycle:
  - CPU write to COUNT beats the tick update; the written value is loaded and no match is evaluated that cycle.
  - CPU write to CTRL beats the one-shot EN clear.
  - A match set beats a STATUS W1C clear, so pending stays 1.
- Reset: CTRL, COUNT, COMPARE, pre_cnt and irq_pending are 0. INTR=0 and IOBUS_IN=0 (address-dependent zero, since all registers are 0).
- RESET asserted mid-count: all state returns to reset values at the next edge. No tick is produced in the reset cycle.
- INTR is registered state ANDed with IRQ_EN. It stays high until software clears STATUS[0] or clears IRQ_EN.

Decomposition:
- Shared package otter_io_pkg holds:
  - Register offset localparams TMR_CTRL=2'd0, TMR_COUNT=2'd1, TMR_CMP=2'd2, TMR_STAT=2'd3.
  - CTRL bit-position constants.
  - Typedef tmr_ctrl_t, a packed struct with prescale, irq_en, auto_reload, en.
- One sub-module, otter_io_prescaler: 8-bit counter with inputs en, clr, limit and output tick.

Test Plan:
1. Reset/readback: assert RESET for 2 cycles, then read 0x..100, 0x..104, 0x..108, 0x..10C → all 0, INTR=0. Write COMPARE=32'hDEAD_BEEF → read returns 32'hDEAD_BEEF. Read 0x..110 → 0.
2. Auto-reload period: COMPARE=3, CTRL=0x07 (EN, AUTO_RELOAD, IRQ_EN, PRESCALE=0) → COUNT sequence 0,1,2,3,0,1,... and INTR rises the cycle after COUNT==3 is ticked. Write STATUS=1 → INTR=0, then INTR reasserts 4 cycles later.
3. One-shot with prescale: COMPARE=2, CTRL=0x0000_0205 (PRESCALE=2, one-shot) → COUNT increments every 3 cycles. After the match, EN reads 0, COUNT holds at 2, and irq_pending=1.
4. Collisions:
   - Force a match tick in the same cycle as a STATUS W1C → pending remains 1.
   - Write COUNT=100 in a tick cycle → COUNT=100 next cycle, not the incremented value.
5. Wrap: COUNT=32'hFFFF_FFFF, COMPARE=5, EN=1, PRESCALE=0 → next COUNT=0 with no interrupt. Interrupt fires at COUNT 5.
6. Reset mid-operation: counting with pending=1 and INTR=1, pulse RESET for 1 cycle → all registers 0 and INTR=0 on the next edge. Counting does not resume until CTRL is rewritten.
